alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Multi-cycle initiator that drives the datapath ALU port: it holds an 8 x 16-bit register file, reads operands, presents them to the ALU, captures the result and Z flag, and writes the result back. It accepts one command at a time over a valid/ready handshake and pulses done on completion. It sits between the lab control logic and the combinational ALU (A, B, op in; result, Z out).

Parameters:
NREGS, 8, number of general registers (index width fixed at 3 bits; NREGS must be 8).
WIDTH, 16, datapath width in bits; must match the ALU.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  block can accept (high only in IDLE)
cmd_kind  in  1  0 = ALU op, 1 = MOVI (load immediate)
cmd_op  in  2  ALU opcode: 00 add, 01 sub, 10 and, 11 not-B
cmd_rd  in  3  destination register
cmd_rn  in  3  operand A register
cmd_rm  in  3  operand B register
cmd_imm  in  16  immediate for MOVI
cmd_shift  in  2  B-operand shift (SHIFTER_EN only)
alu_a  out  16  ALU operand A (registered)
alu_b  out  16  ALU operand B (registered)
alu_op  out  2  ALU opcode (registered)
alu_out  in  16  ALU result
alu_z  in  1  ALU zero flag
done  out  1  one-cycle completion pulse
status_z  out  1  Z flag of last ALU command
rd_sel  in  3  debug register select
rd_data  out  16  R[rd_sel], combinational read

Behaviour:
- Reset (rst_n low, async): state IDLE; R0-R7 = 0; alu_a, alu_b, result holding register = 0; alu_op = 00; done = 0; status_z = 0. Reset mid-command aborts with no writeback and no done.
- Handshake: cmd_ready = (state == IDLE). Accept when cmd_valid & cmd_ready at a rising edge; all cmd_* fields latched then. cmd_* ignored in other states. cmd_valid low in IDLE: stay IDLE.
- FSM states: IDLE, RD_A, RD_B, EXEC, WB.
- ALU path: IDLE -(accept)-> RD_A: alu_a <= R[rn], alu_op <= latched op. RD_A -> RD_B: alu_b <= R[rm] (shifted if enabled). RD_B -> EXEC: result reg <= alu_out, status_z <= alu_z. EXEC -> WB: R[rd] <= result reg. WB -> IDLE.
- MOVI path: IDLE -(accept)-> WB with result reg <= cmd_imm; WB writes R[rd]; status_z unchanged; alu_a/alu_b/alu_op unchanged.
- done: registered, high exactly one cycle, the cycle after WB (state IDLE, cmd_ready high). Acceptance at edge T: ALU done at T+5, MOVI done at T+2. New command may be accepted in the done cycle.
- rd_data reflects writeback from the first cycle done is high.
- rn == rm == rd allowed; operands read before writeback, so no hazard.
- Arithmetic is modulo 2^16; carry/overflow discarded. 11 ignores A.
- alu_a/alu_b/alu_op hold their values between commands.

Optional Feature:
SHIFTER_EN: when defined, RD_B loads alu_b <= shift(R[rm]) by latched cmd_shift: 00 none, 01 shift left 1 (zero fill), 10 logical shift right 1, 11 arithmetic shift right 1 (bit 15 replicated). When not defined, cmd_shift is ignored and alu_b <= R[rm] unshifted.

Test Plan:
- Reset then MOVI R1=0x0005 -> cmd_ready low 1 cycle, done at T+2, rd_data(rd_sel=1)=0x0005, status_z=0.
- MOVI R1=5, R2=3; ADD R3=R1+R2 -> alu_a=0x0005, alu_b=0x0003, alu_op=00, done at T+5, R3=0x0008, status_z=0.
- SUB R4=R1-R1 (5-5) -> R4=0x0000, status_z=1; subsequent MOVI R5=0x0000 leaves status_z=1.
- MOVI R6=0xFFFF, R7=0x0001; ADD R6=R6+R7 -> R6=0x0000 (wrap), status_z=1; NOT R0=~R7 -> R0=0xFFFE, status_z=0.
- rst_n low during EXEC of ADD R3 (R3 previously 0x0008) -> state IDLE, all registers 0, no done pulse; cmd_valid held high through reset -> accepted on first edge after release.
- SHIFTER_EN: R2=0x8003, AND R3=R6(0xFFFF) & (R2 ASR1) -> R3=0xC001; LSR1 -> 0x4001; without macro same command -> R3=0x8003.

Source files
------------

// File: rtl/alu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Multi-cycle initiator for a combinational ALU. Holds an
//               8 x WIDTH register file, stages operands onto the ALU port,
//               captures the result and zero flag, and writes the result
//               back. Commands arrive one at a time over valid/ready and
//               completion is signalled by a one-cycle done pulse.
//               Optional feature macro: SHIFTER_EN (B-operand shifter).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
  parameter int NREGS = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_kind,
  input  logic [1:0]       cmd_op,
  input  logic [2:0]       cmd_rd,
  input  logic [2:0]       cmd_rn,
  input  logic [2:0]       cmd_rm,
  input  logic [WIDTH-1:0] cmd_imm,
  input  logic [1:0]       cmd_shift,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_z,
  output logic             done,
  output logic             status_z,
  input  logic [2:0]       rd_sel,
  output logic [WIDTH-1:0] rd_data
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4
  } state_t;

  state_t           state;
  logic [2:0]       lat_rd;
  logic [2:0]       lat_rm;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] b_operand;

  // A command is only taken while idle; busy states ignore cmd_* entirely.
  assign cmd_ready = (state == IDLE);

  // Debug read port is a plain combinational lookup of the register file.
  assign rd_data = regs[rd_sel];

`ifdef SHIFTER_EN
  logic [1:0] lat_shift;

  // Shift by one position as selected by the latched command shift code.
  function automatic logic [WIDTH-1:0] shift_b(input logic [WIDTH-1:0] v,
                                               input logic [1:0]       s);
    case (s)
      2'b01:   shift_b = {v[WIDTH-2:0], 1'b0};
      2'b10:   shift_b = {1'b0, v[WIDTH-1:1]};
      2'b11:   shift_b = {v[WIDTH-1], v[WIDTH-1:1]};
      default: shift_b = v;
    endcase
  endfunction

  assign b_operand = shift_b(regs[lat_rm], lat_shift);

  // Shift code is captured with the rest of the command at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_shift <= 2'b00;
    end else if (state == IDLE && cmd_valid) begin
      lat_shift <= cmd_shift;
    end
  end
`else
  // Without the shifter the shift field has no effect on the datapath.
  logic unused_shift;
  assign unused_shift = ^cmd_shift;
  assign b_operand    = regs[lat_rm];
`endif

  // Sequencer: operand staging, result capture, writeback and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lat_rd   <= 3'd0;
      lat_rm   <= 3'd0;
      result   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= 2'b00;
      done     <= 1'b0;
      status_z <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            lat_rd <= cmd_rd;
            lat_rm <= cmd_rm;
            if (cmd_kind) begin
              // Load immediate skips the ALU and leaves its port untouched.
              result <= cmd_imm;
              state  <= WB;
            end else begin
              alu_a  <= regs[cmd_rn];
              alu_op <= cmd_op;
              state  <= RD_A;
            end
          end
        end
        RD_A: begin
          alu_b <= b_operand;
          state <= RD_B;
        end
        RD_B: begin
          result   <= alu_out;
          status_z <= alu_z;
          state    <= EXEC;
        end
        EXEC: begin
          regs[lat_rd] <= result;
          state        <= WB;
        end
        WB: begin
          // Rewriting the same value is harmless for ALU commands and is
          // the only writeback for load-immediate.
          regs[lat_rd] <= result;
          done         <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Self-checking bench for alu_sequencer with a behavioural
//               ALU and a register-file model feeding a result scoreboard.
//               Honours SHIFTER_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_kind;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_rd;
  logic [2:0]  cmd_rn;
  logic [2:0]  cmd_rm;
  logic [15:0] cmd_imm;
  logic [1:0]  cmd_shift;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [1:0]  alu_op;
  logic [15:0] alu_out;
  logic        alu_z;
  logic        done;
  logic        status_z;
  logic [2:0]  rd_sel;
  logic [15:0] rd_data;

  always #5 clk = ~clk;

  alu_sequencer #(.NREGS(8), .WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
    .cmd_imm(cmd_imm), .cmd_shift(cmd_shift),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_z(alu_z),
    .done(done), .status_z(status_z),
    .rd_sel(rd_sel), .rd_data(rd_data)
  );

  // Behavioural combinational ALU on the other side of the port.
  always_comb begin
    alu_out = 16'h0000;
    case (alu_op)
      2'b00:   alu_out = alu_a + alu_b;
      2'b01:   alu_out = alu_a - alu_b;
      2'b10:   alu_out = alu_a & alu_b;
      default: alu_out = ~alu_b;
    endcase
  end
  assign alu_z = (alu_out == 16'h0000);

`ifdef SHIFTER_EN
  localparam bit SHIFT_ON = 1'b1;
`else
  localparam bit SHIFT_ON = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  rd;
    logic [15:0] val;
    logic        z;
    logic [3:0]  lat;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] mregs [8];
  logic        mz;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [15:0] m_shift(input logic [15:0] v, input logic [1:0] s);
    if (!SHIFT_ON) return v;
    case (s)
      2'b01:   return {v[14:0], 1'b0};
      2'b10:   return {1'b0, v[15:1]};
      2'b11:   return {v[15], v[15:1]};
      default: return v;
    endcase
  endfunction

  task automatic apply_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_kind  = 1'b0;
    cmd_op    = 2'b00;
    cmd_rd    = 3'd0;
    cmd_rn    = 3'd0;
    cmd_rm    = 3'd0;
    cmd_imm   = 16'h0000;
    cmd_shift = 2'b00;
    rd_sel    = 3'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
    mz = 1'b0;
    sb.delete();
  endtask

  // Issue one command from a negedge; returns at the negedge where done is seen.
  task automatic send(input logic kind, input logic [1:0] op, input logic [2:0] rd,
                      input logic [2:0] rn, input logic [2:0] rm,
                      input logic [15:0] imm, input logic [1:0] sh);
    exp_t        e;
    logic [15:0] a;
    logic [15:0] b;
    int          k;
    e.rd = rd;
    if (kind) begin
      e.val = imm;
      e.z   = mz;
      e.lat = 4'd2;
    end else begin
      a = mregs[rn];
      b = m_shift(mregs[rm], sh);
      case (op)
        2'b00:   e.val = a + b;
        2'b01:   e.val = a - b;
        2'b10:   e.val = a & b;
        default: e.val = ~b;
      endcase
      e.z   = (e.val == 16'h0000);
      e.lat = 4'd5;
    end
    mregs[rd] = e.val;
    mz        = e.z;
    sb.push_back(e);

    cmd_kind  = kind;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rn    = rn;
    cmd_rm    = rm;
    cmd_imm   = imm;
    cmd_shift = sh;
    cmd_valid = 1'b1;
    rd_sel    = rd;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_idle: got %b expected 1", cmd_ready);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_busy: got %b expected 0", cmd_ready);
    end
    k = 1;
    while (done !== 1'b1 && k < 12) begin
      @(negedge clk);
      k++;
    end
    e = sb.pop_front();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: rd=%0d no done within %0d cycles", e.rd, k);
    end else begin
      checks++;
      if (k != int'(e.lat)) begin
        errors++;
        $display("FAIL done_latency: got %0d expected %0d", k, e.lat);
      end
      checks++;
      if (rd_data !== e.val) begin
        errors++;
        $display("FAIL writeback R%0d: got %h expected %h", e.rd, rd_data, e.val);
      end
      checks++;
      if (status_z !== e.z) begin
        errors++;
        $display("FAIL status_z: got %b expected %b", status_z, e.z);
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL ready_in_done: got %b expected 1", cmd_ready);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if ({cmd_ready, done, status_z, alu_op} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got ready/done/z/op=%b expected 10000",
               {cmd_ready, done, status_z, alu_op});
    end
    checks++;
    if ({alu_a, alu_b} !== 32'h0) begin
      errors++;
      $display("FAIL reset_alu_ports: got a=%h b=%h expected 0", alu_a, alu_b);
    end
    for (int i = 0; i < 8; i++) begin
      rd_sel = 3'(i);
      #1;
      checks++;
      if (rd_data !== 16'h0000) begin
        errors++;
        $display("FAIL reset_reg R%0d: got %h expected 0000", i, rd_data);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_movi();
    send(1'b1, 2'b00, 3'd1, 3'd0, 3'd0, 16'h0005, 2'b00);
    checks++;
    if (rd_data !== 16'h0005 || status_z !== 1'b0) begin
      errors++;
      $display("FAIL movi_r1: got %h z=%b expected 0005 z=0", rd_data, status_z);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_width: got %b expected 0", done);
    end
  endtask

  task automatic test_add();
    send(1'b1, 2'b00, 3'd2, 3'd0, 3'd0, 16'h0003, 2'b00);
    send(1'b0, 2'b00, 3'd3, 3'd1, 3'd2, 16'h0000, 2'b00);
    checks++;
    if (alu_a !== 16'h0005 || alu_b !== 16'h0003 || alu_op !== 2'b00) begin
      errors++;
      $display("FAIL add_ports: got a=%h b=%h op=%b expected 0005 0003 00", alu_a, alu_b, alu_op);
    end
    checks++;
    if (rd_data !== 16'h0008) begin
      errors++;
      $display("FAIL add_r3: got %h expected 0008", rd_data);
    end
  endtask

  task automatic test_sub_zero();
    send(1'b0, 2'b01, 3'd4, 3'd1, 3'd1, 16'h0000, 2'b00);
    checks++;
    if (rd_data !== 16'h0000 || status_z !== 1'b1) begin
      errors++;
      $display("FAIL sub_zero: got %h z=%b expected 0000 z=1", rd_data, status_z);
    end
    send(1'b1, 2'b00, 3'd5, 3'd0, 3'd0, 16'h0000, 2'b00);
    checks++;
    if (status_z !== 1'b1 || alu_op !== 2'b01 || alu_a !== 16'h0005) begin
      errors++;
      $display("FAIL movi_holds: got z=%b op=%b a=%h expected 1 01 0005", status_z, alu_op, alu_a);
    end
  endtask

  task automatic test_wrap_not();
    send(1'b1, 2'b00, 3'd6, 3'd0, 3'd0, 16'hFFFF, 2'b00);
    send(1'b1, 2'b00, 3'd7, 3'd0, 3'd0, 16'h0001, 2'b00);
    send(1'b0, 2'b00, 3'd6, 3'd6, 3'd7, 16'h0000, 2'b00);
    checks++;
    if (rd_data !== 16'h0000 || status_z !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap: got %h z=%b expected 0000 z=1", rd_data, status_z);
    end
    send(1'b0, 2'b11, 3'd0, 3'd3, 3'd7, 16'h0000, 2'b00);
    checks++;
    if (rd_data !== 16'hFFFE || status_z !== 1'b0) begin
      errors++;
      $display("FAIL not_b: got %h z=%b expected fffe z=0", rd_data, status_z);
    end
  endtask

  task automatic test_reset_midcmd();
    int k;
    // ADD R3 = R1 + R2, aborted while in EXEC.
    cmd_kind  = 1'b0;
    cmd_op    = 2'b00;
    cmd_rd    = 3'd3;
    cmd_rn    = 3'd1;
    cmd_rm    = 3'd2;
    cmd_shift = 2'b00;
    cmd_valid = 1'b1;
    rd_sel    = 3'd3;
    @(posedge clk);
    @(negedge clk);
    // Switch the offered command to MOVI R2 and keep it valid through reset.
    cmd_kind = 1'b1;
    cmd_rd   = 3'd2;
    cmd_imm  = 16'h1234;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || status_z !== 1'b0 || alu_a !== 16'h0000) begin
      errors++;
      $display("FAIL abort_state: got ready=%b done=%b z=%b a=%h expected 1 0 0 0000",
               cmd_ready, done, status_z, alu_a);
    end
    for (int i = 0; i < 8; i++) begin
      rd_sel = 3'(i);
      #1;
      checks++;
      if (rd_data !== 16'h0000) begin
        errors++;
        $display("FAIL abort_reg R%0d: got %h expected 0000", i, rd_data);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL abort_done: got %b expected 0", done);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
    mz        = 1'b0;
    mregs[2]  = 16'h1234;
    sb.push_back('{rd: 3'd2, val: 16'h1234, z: 1'b0, lat: 4'd2});
    rd_sel = 3'd2;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 1;
    while (done !== 1'b1 && k < 12) begin
      @(negedge clk);
      k++;
    end
    begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (done !== 1'b1 || k != int'(e.lat) || rd_data !== e.val) begin
        errors++;
        $display("FAIL post_reset_accept: got done=%b lat=%0d data=%h expected 1 %0d %h",
                 done, k, rd_data, e.lat, e.val);
      end
    end
    rd_sel = 3'd3;
    #1;
    checks++;
    if (rd_data !== 16'h0000) begin
      errors++;
      $display("FAIL abort_no_wb: got %h expected 0000", rd_data);
    end
    @(negedge clk);
  endtask

  task automatic test_shift();
    send(1'b1, 2'b00, 3'd2, 3'd0, 3'd0, 16'h8003, 2'b00);
    send(1'b1, 2'b00, 3'd6, 3'd0, 3'd0, 16'hFFFF, 2'b00);
    send(1'b0, 2'b10, 3'd3, 3'd6, 3'd2, 16'h0000, 2'b11);
    checks++;
    if (rd_data !== (SHIFT_ON ? 16'hC001 : 16'h8003)) begin
      errors++;
      $display("FAIL shift_asr: got %h expected %h", rd_data, SHIFT_ON ? 16'hC001 : 16'h8003);
    end
    send(1'b0, 2'b10, 3'd3, 3'd6, 3'd2, 16'h0000, 2'b10);
    checks++;
    if (rd_data !== (SHIFT_ON ? 16'h4001 : 16'h8003)) begin
      errors++;
      $display("FAIL shift_lsr: got %h expected %h", rd_data, SHIFT_ON ? 16'h4001 : 16'h8003);
    end
    send(1'b0, 2'b00, 3'd4, 3'd0, 3'd2, 16'h0000, 2'b01);
    checks++;
    if (alu_b !== (SHIFT_ON ? 16'h0006 : 16'h8003)) begin
      errors++;
      $display("FAIL shift_lsl: got %h expected %h", alu_b, SHIFT_ON ? 16'h0006 : 16'h8003);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      send(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 16'($urandom),
           2'($urandom_range(0, 3)));
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_width: got %b expected 0", done);
    end
  endtask

  initial begin
    test_reset();
    test_movi();
    test_add();
    test_sub_zero();
    test_wrap_not();
    test_reset_midcmd();
    test_shift();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
